// File: rtl/mem_bus_arbiter.sv
// Two-port (icache = port 0, dcache = port 1) arbiter onto a single DRAM-side bus.
// Whole transactions are granted at a time, with round-robin tie-break and combinational data pass-through.
`default_nettype none

module mem_bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      p0_bus_reqcyc,
  output logic                      p0_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] p0_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p0_bus_reqtag,
  output logic                      p0_bus_respcyc,
  input  logic                      p0_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] p0_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p0_bus_resptag,

  input  logic                      p1_bus_reqcyc,
  output logic                      p1_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] p1_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p1_bus_reqtag,
  output logic                      p1_bus_respcyc,
  input  logic                      p1_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] p1_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p1_bus_resptag,

  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

  localparam int       READ_BIT  = 12;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state, state_n;
  logic       grant, grant_n;
  logic       last_grant, last_grant_n;
  logic       is_read, is_read_n;
  logic [2:0] cnt, cnt_n;

  logic                      g_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] g_req;
  logic [BUS_TAG_WIDTH-1:0]  g_reqtag;
  logic                      g_respack;
  logic                      beat_xfer;

  assign g_reqcyc  = grant ? p1_bus_reqcyc  : p0_bus_reqcyc;
  assign g_req     = grant ? p1_bus_req     : p0_bus_req;
  assign g_reqtag  = grant ? p1_bus_reqtag  : p0_bus_reqtag;
  assign g_respack = grant ? p1_bus_respack : p0_bus_respack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      is_read    <= 1'b0;
      cnt        <= 3'd0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      is_read    <= is_read_n;
      cnt        <= cnt_n;
    end
  end

  // Datapath muxing: everything is zero unless the granted port is in the matching phase.
  always_comb begin
    p0_bus_reqack  = 1'b0;
    p1_bus_reqack  = 1'b0;
    p0_bus_respcyc = 1'b0;
    p1_bus_respcyc = 1'b0;
    p0_bus_resp    = '0;
    p1_bus_resp    = '0;
    p0_bus_resptag = '0;
    p1_bus_resptag = '0;
    m_bus_reqcyc   = 1'b0;
    m_bus_req      = '0;
    m_bus_reqtag   = '0;
    m_bus_respack  = 1'b0;

    if (state == REQ || state == WDATA) begin
      m_bus_reqcyc = g_reqcyc;
      m_bus_req    = g_req;
      m_bus_reqtag = g_reqtag;
      if (grant) p1_bus_reqack = m_bus_reqack;
      else       p0_bus_reqack = m_bus_reqack;
    end

    if (state == RESP) begin
      m_bus_respack = g_respack;
      if (grant) begin
        p1_bus_respcyc = m_bus_respcyc;
        p1_bus_resp    = m_bus_resp;
        p1_bus_resptag = m_bus_resptag;
      end else begin
        p0_bus_respcyc = m_bus_respcyc;
        p0_bus_resp    = m_bus_resp;
        p0_bus_resptag = m_bus_resptag;
      end
    end
  end

  // Data-phase beats are counted on the response channel for reads and the request channel for writes.
  assign beat_xfer = is_read ? (m_bus_respcyc && m_bus_respack)
                             : (m_bus_reqcyc && m_bus_reqack);

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    is_read_n    = is_read;
    cnt_n        = cnt;

    case (state)
      IDLE: begin
        if (p0_bus_reqcyc || p1_bus_reqcyc) begin
          state_n = REQ;
          if (p0_bus_reqcyc && p1_bus_reqcyc) grant_n = ~last_grant;
          else                                grant_n = p1_bus_reqcyc;
        end
      end
      REQ: begin
        if (g_reqcyc && m_bus_reqack) begin
          is_read_n = g_reqtag[READ_BIT];
          cnt_n     = 3'd0;
          state_n   = g_reqtag[READ_BIT] ? RESP : WDATA;
        end else if (!g_reqcyc) begin
          state_n = IDLE;
        end
      end
      WDATA, RESP: begin
        if (beat_xfer) begin
          cnt_n = cnt + 3'd1;
          if (cnt == LAST_BEAT) begin
            state_n      = IDLE;
            last_grant_n = grant;
            cnt_n        = 3'd0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reads, writes, ties, abandon, response stall and mid-cycle reset.
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_reqcyc, p0_reqack, p0_respcyc, p0_respack;
  logic [63:0] p0_req, p0_resp;
  logic [12:0] p0_reqtag, p0_resptag;
  logic        p1_reqcyc, p1_reqack, p1_respcyc, p1_respack;
  logic [63:0] p1_req, p1_resp;
  logic [12:0] p1_reqtag, p1_resptag;
  logic        m_reqcyc, m_reqack, m_respcyc, m_respack;
  logic [63:0] m_req, m_resp;
  logic [12:0] m_reqtag, m_resptag;

  int n_total = 0;
  int n_bad   = 0;
  int req_beats  = 0;
  int resp_beats = 0;
  int base;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_bus_reqcyc(p0_reqcyc), .p0_bus_reqack(p0_reqack), .p0_bus_req(p0_req),
    .p0_bus_reqtag(p0_reqtag), .p0_bus_respcyc(p0_respcyc), .p0_bus_respack(p0_respack),
    .p0_bus_resp(p0_resp), .p0_bus_resptag(p0_resptag),
    .p1_bus_reqcyc(p1_reqcyc), .p1_bus_reqack(p1_reqack), .p1_bus_req(p1_req),
    .p1_bus_reqtag(p1_reqtag), .p1_bus_respcyc(p1_respcyc), .p1_bus_respack(p1_respack),
    .p1_bus_resp(p1_resp), .p1_bus_resptag(p1_resptag),
    .m_bus_reqcyc(m_reqcyc), .m_bus_reqack(m_reqack), .m_bus_req(m_req),
    .m_bus_reqtag(m_reqtag), .m_bus_respcyc(m_respcyc), .m_bus_respack(m_respack),
    .m_bus_resp(m_resp), .m_bus_resptag(m_resptag)
  );

  always @(posedge clk) begin
    if (m_reqcyc && m_reqack)   req_beats  <= req_beats + 1;
    if (m_respcyc && m_respack) resp_beats <= resp_beats + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    p0_reqcyc = 0; p0_req = '0; p0_reqtag = '0; p0_respack = 0;
    p1_reqcyc = 0; p1_req = '0; p1_reqtag = '0; p1_respack = 0;
    m_reqack = 1; m_respcyc = 0; m_resp = '0; m_resptag = '0;

    // Reset state, including inputs active during reset
    #2;
    check("rst_m_reqcyc", m_reqcyc, 0);
    check("rst_m_respack", m_respack, 0);
    p0_reqcyc = 1; p0_req = 64'h77; m_respcyc = 1; m_resp = 64'hFF; p0_respack = 1;
    #1;
    check("rst_m_req", m_req, 0);
    check("rst_p0_reqack", p0_reqack, 0);
    check("rst_p0_respcyc", p0_respcyc, 0);
    check("rst_p0_resp", p0_resp, 0);
    check("rst_respack", m_respack, 0);
    p0_reqcyc = 0; m_respcyc = 0; m_resp = '0; p0_respack = 0;
    tick(); tick();
    reset = 1'b1;

    // p0 read of 0x1000
    p0_reqcyc = 1; p0_req = 64'h1000; p0_reqtag = 13'h1001;
    #1;
    check("idle_m_reqcyc", m_reqcyc, 0);
    check("idle_p0_reqack", p0_reqack, 0);
    base = req_beats;
    tick();
    check("rd_m_reqcyc", m_reqcyc, 1);
    check("rd_m_req", m_req, 64'h1000);
    check("rd_m_reqtag", m_reqtag, 13'h1001);
    check("rd_p0_reqack", p0_reqack, 1);
    check("rd_p1_reqack", p1_reqack, 0);
    tick();
    check("rd_addr_beats", req_beats - base, 1);
    p0_reqcyc = 0; p0_respack = 1; m_respcyc = 1; m_resptag = 13'h1001;
    base = resp_beats;
    for (int i = 0; i < 8; i++) begin
      m_resp = 64'hA0 + 64'(i);
      #1;
      check("rd_p0_respcyc", p0_respcyc, 1);
      check("rd_p0_resp", p0_resp, 64'hA0 + 64'(i));
      check("rd_p0_resptag", p0_resptag, 13'h1001);
      check("rd_p1_respcyc", p1_respcyc, 0);
      check("rd_m_respack", m_respack, 1);
      tick();
    end
    check("rd_resp_beats", resp_beats - base, 8);
    check("stray_m_respack", m_respack, 0);
    check("stray_p0_respcyc", p0_respcyc, 0);
    m_respcyc = 0; p0_respack = 0;

    // p1 write of 0x2040 plus 8 data beats
    p1_reqcyc = 1; p1_req = 64'h2040; p1_reqtag = 13'h0002;
    base = req_beats;
    tick();
    check("wr_m_req", m_req, 64'h2040);
    check("wr_m_reqtag", m_reqtag, 13'h0002);
    check("wr_p1_reqack", p1_reqack, 1);
    check("wr_p0_reqack", p0_reqack, 0);
    tick();
    m_respcyc = 1;
    for (int i = 0; i < 8; i++) begin
      p1_req = 64'hD0 + 64'(i);
      #1;
      check("wr_data", m_req, 64'hD0 + 64'(i));
      check("wr_data_cyc", m_reqcyc, 1);
      check("wr_no_respack", m_respack, 0);
      check("wr_no_p1_respcyc", p1_respcyc, 0);
      tick();
    end
    p1_reqcyc = 0; m_respcyc = 0;
    #1;
    check("wr_beats", req_beats - base, 9);
    check("wr_idle_after", m_reqcyc, 0);

    // Fresh reset, then p0 abandons its request before acceptance
    reset = 1'b0;
    tick();
    reset = 1'b1;
    p0_reqcyc = 1; p0_req = 64'h5000; p0_reqtag = 13'h1005; m_reqack = 0;
    tick();
    check("abn_m_reqcyc", m_reqcyc, 1);
    check("abn_p0_reqack", p0_reqack, 0);
    p0_reqcyc = 0;
    #1;
    check("abn_drop", m_reqcyc, 0);
    tick();
    m_reqack = 1;

    // Tie: p0 must win, p1 waits holding reqcyc
    p0_reqcyc = 1; p0_req = 64'h3000; p0_reqtag = 13'h1003;
    p1_reqcyc = 1; p1_req = 64'h4000; p1_reqtag = 13'h1004;
    #1;
    check("tie_idle", m_reqcyc, 0);
    tick();
    check("tie_m_req", m_req, 64'h3000);
    check("tie_p0_reqack", p0_reqack, 1);
    check("tie_p1_reqack", p1_reqack, 0);
    tick();
    p0_reqcyc = 0; m_respcyc = 1; m_resptag = 13'h1003;
    base = resp_beats;
    for (int k = 0; k < 8; k++) begin
      m_resp = 64'hA0 + 64'(k);
      if (k == 3) begin
        p0_respack = 0;
        repeat (3) begin
          #1;
          check("stall_m_respack", m_respack, 0);
          check("stall_p0_resp", p0_resp, 64'hA3);
          check("stall_p0_respcyc", p0_respcyc, 1);
          tick();
        end
      end
      p0_respack = 1;
      #1;
      check("stall_beat", p0_resp, 64'hA0 + 64'(k));
      check("stall_ack", m_respack, 1);
      check("stall_p1_respcyc", p1_respcyc, 0);
      tick();
    end
    check("stall_beats", resp_beats - base, 8);
    m_respcyc = 0; p0_respack = 0;
    #1;
    check("gap_m_reqcyc", m_reqcyc, 0);
    check("gap_p1_reqack", p1_reqack, 0);
    tick();
    check("p1_after_m_req", m_req, 64'h4000);
    check("p1_after_reqack", p1_reqack, 1);
    check("p1_after_p0_reqack", p0_reqack, 0);
    tick();
    p1_reqcyc = 0; p1_respack = 1; m_respcyc = 1; m_resptag = 13'h1004;
    for (int k = 0; k < 8; k++) begin
      m_resp = 64'hB0 + 64'(k);
      #1;
      check("p1_resp", p1_resp, 64'hB0 + 64'(k));
      check("p1_resptag", p1_resptag, 13'h1004);
      check("p1_p0_respcyc", p0_respcyc, 0);
      tick();
    end
    m_respcyc = 0; p1_respack = 0;

    // Second tie goes to p0 again; reset lands mid-cycle on its 5th response beat
    p0_reqcyc = 1; p0_req = 64'h3100; p0_reqtag = 13'h1006;
    p1_reqcyc = 1; p1_req = 64'h4100; p1_reqtag = 13'h1007;
    tick();
    check("tie2_m_req", m_req, 64'h3100);
    check("tie2_p0_reqack", p0_reqack, 1);
    tick();
    p0_reqcyc = 0; p0_respack = 1; m_respcyc = 1; m_resptag = 13'h1006;
    for (int k = 0; k < 4; k++) begin
      m_resp = 64'hE0 + 64'(k);
      tick();
    end
    m_resp = 64'hE4;
    #1;
    check("pre_rst_beat4", p0_resp, 64'hE4);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_p0_respcyc", p0_respcyc, 0);
    check("mid_rst_p0_resp", p0_resp, 0);
    check("mid_rst_p0_resptag", p0_resptag, 0);
    check("mid_rst_m_respack", m_respack, 0);
    check("mid_rst_m_reqcyc", m_reqcyc, 0);
    check("mid_rst_m_req", m_req, 0);
    check("mid_rst_p1_reqack", p1_reqack, 0);
    tick();
    check("in_rst_m_reqcyc", m_reqcyc, 0);
    check("in_rst_p1_respcyc", p1_respcyc, 0);
    reset = 1'b1; m_respcyc = 0; p0_respack = 0;
    #1;
    check("post_rst_idle", m_reqcyc, 0);
    tick();
    check("post_rst_m_req", m_req, 64'h4100);
    check("post_rst_p1_reqack", p1_reqack, 1);
    tick();
    p1_reqcyc = 0; p1_respack = 1; m_respcyc = 1; m_resptag = 13'h1007;
    base = resp_beats;
    for (int k = 0; k < 8; k++) begin
      m_resp = 64'hC0 + 64'(k);
      #1;
      check("post_rst_p1_resp", p1_resp, 64'hC0 + 64'(k));
      tick();
    end
    check("post_rst_beats", resp_beats - base, 8);
    check("post_rst_done", p1_respcyc, 0);
    m_respcyc = 0; p1_respack = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Two-requester (instruction cache = port 0, data cache = port 1) arbiter onto the single DRAM-side bus consumed by the set-associative caches' memory interface. One whole transaction at a time, grant held until transaction completion.

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, width of address/data beats.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, width of tags; bit 12 = 1 read, 0 write.
REQ-003 SHALL have parameter BEATS, default 8, data beats per 512-bit line.
REQ-004 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have, for N in {0,1}, pN_bus_reqcyc  input  1  requester N beat valid.
REQ-007 SHALL have pN_bus_reqack  output  1  beat accepted to requester N.
REQ-008 SHALL have pN_bus_req  input  BUS_DATA_WIDTH  address or write-data beat.
REQ-009 SHALL have pN_bus_reqtag  input  BUS_TAG_WIDTH  request tag.
REQ-010 SHALL have pN_bus_respcyc  output  1  response beat valid to requester N.
REQ-011 SHALL have pN_bus_respack  input  1  requester N accepts response beat.
REQ-012 SHALL have pN_bus_resp  output  BUS_DATA_WIDTH  response data.
REQ-013 SHALL have pN_bus_resptag  output  BUS_TAG_WIDTH  response tag.
REQ-014 SHALL have m_bus_reqcyc / m_bus_reqack / m_bus_req / m_bus_reqtag (out/in/out/out, 1/1/BUS_DATA_WIDTH/BUS_TAG_WIDTH) memory request channel.
REQ-015 SHALL have m_bus_respcyc / m_bus_respack / m_bus_resp / m_bus_resptag (in/out/in/in, 1/1/BUS_DATA_WIDTH/BUS_TAG_WIDTH) memory response channel.

Function
REQ-016 A beat SHALL transfer on a rising edge where cyc and ack are both 1.
REQ-017 FSM states SHALL be IDLE, REQ, WDATA, RESP; registered state, grant (1 bit), last_grant (1 bit), is_read (1 bit), beat counter (3 bits).
REQ-018 In IDLE no output cyc/ack SHALL be asserted; on an edge with any pN_bus_reqcyc=1, grant SHALL be registered and state -> REQ.
REQ-019 Single requester SHALL win; both requesting SHALL grant the port != last_grant; last_grant after reset SHALL be 1 (port 0 wins first tie).
REQ-020 In REQ/WDATA, m_bus_reqcyc/req/reqtag SHALL combinationally mirror the granted port; granted pN_bus_reqack SHALL equal m_bus_reqack; non-granted reqack SHALL be 0.
REQ-021 On the REQ address beat, is_read SHALL latch reqtag[12]; read -> RESP, write -> WDATA, counter cleared.
REQ-022 If granted reqcyc drops in REQ before acceptance, state SHALL return to IDLE, last_grant unchanged.
REQ-023 WDATA SHALL count accepted beats; on the BEATS-th beat state -> IDLE, last_grant <= grant.
REQ-024 In RESP, granted pN_bus_respcyc/resp/resptag SHALL mirror m_bus_respcyc/resp/resptag; m_bus_respack SHALL equal granted pN_bus_respack; non-granted resp outputs SHALL be 0.
REQ-025 RESP SHALL count accepted response beats; BEATS-th -> IDLE, last_grant <= grant.
REQ-026 Outside RESP m_bus_respack SHALL be 0 and stray m_bus_respcyc SHALL be ignored.
REQ-027 Non-granted request SHALL wait holding reqcyc; it SHALL be granted in the IDLE cycle immediately after completion (one idle cycle between transactions).
REQ-028 Arbiter-added latency SHALL be exactly one cycle (IDLE->REQ); data paths SHALL be combinational pass-through.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, grant=0, last_grant=1, counter=0, is_read=0, independent of clk.
REQ-030 During reset all cyc/ack outputs SHALL be 0 and all data/tag outputs 0.
REQ-031 Reset mid-transaction SHALL abandon it; no beats SHALL be forwarded until reset=1 and a new IDLE arbitration.

Verification
REQ-032 p0 read addr 0x1000 tag 0x1001, memory returns 8 beats 0xA0..0xA7 -> m_bus_req=0x1000 second cycle; p0 receives 0xA0..0xA7 in order; p1 respcyc stays 0.
REQ-033 p1 write addr 0x2040 tag 0x0002 + 8 data beats 0xD0..0xD7 -> m_bus sees 9 accepted beats in order, no response phase, IDLE after 9th.
REQ-034 p0 and p1 request same cycle after reset -> p0 served first; p1 granted in the IDLE cycle after p0's 8th beat; next tie goes to p0.
REQ-035 m_bus_respack stalls: p0 holds respack=0 three cycles on beat 3 -> m_bus_respack=0 those cycles, no beat lost or duplicated.
REQ-036 reset=0 asserted mid-clock during RESP beat 4 -> all outputs 0 before next edge; after release p1 request served normally.
